// File: rtl/dm_cache.sv
// ----------------------------------------------------------------------------
// dm_cache -- direct-mapped, write-through, no-write-allocate cache.
//
// A CPU load that hits returns its word combinationally with no stall. A load
// miss stalls, fetches the whole line from memory one word per beat, then
// completes in the following IDLE cycle as a hit. A store is always written
// through to memory. If the line is cached, the cached word is updated in the
// same cycle as mem_wr_ack. A store to an uncached line does not allocate it.
//
// Optional build macro: DM_CACHE_STATS_EN adds saturating hit_cnt / miss_cnt.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cpu_rd, cpu_wr    load / store request (held while stall=1)
//   cpu_addr          byte address of the request
//   cpu_wdata         store data
//   cpu_rdata         load data (valid when cpu_rd=1 and stall=0)
//   stall             CPU must hold its request
//   hit               combinational tag hit for cpu_addr
//   mem_rd_req        line-fill request, held until the last beat
//   mem_addr          line-aligned address in FILL, word-aligned otherwise
//   mem_rd_valid      one fill beat present on mem_rd_data
//   mem_rd_data       fill beat data, ascending word order
//   mem_wr_req        write-through request, held until mem_wr_ack
//   mem_wdata         store data to memory
//   mem_wr_ack        single-cycle write completion
//   hit_cnt, miss_cnt (DM_CACHE_STATS_EN only) read-hit and line-fill counts
// ----------------------------------------------------------------------------
module dm_cache #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 128,
    parameter int WORDS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              hit,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_req,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wr_ack
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    // Address split, LSB first: byte offset | word select | index | tag.
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int WSEL_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int FLAT_W = WSEL_W + IDX_W;     // word index into the data array
    localparam int TAG_W  = ADDR_W - OFF_W - FLAT_W;
    localparam int BEAT_W = (WORDS > 1) ? WSEL_W : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ADDR_W'((DATA_W / 8) - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(WORDS * (DATA_W / 8) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic [LINES-1:0]    valid;
    logic [DATA_W-1:0]   data_mem [LINES*WORDS];
    logic [TAG_W-1:0]    tag_mem  [LINES];

    logic [FLAT_W-1:0]   req_flat;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [FLAT_W-1:0]   fill_flat;
    logic                rd_hit;
    logic                last_beat;

    assign req_flat = cpu_addr[OFF_W +: FLAT_W];
    assign req_idx  = cpu_addr[OFF_W + WSEL_W +: IDX_W];
    assign req_tag  = cpu_addr[ADDR_W-1 -: TAG_W];

    // Fill writes go to the current line at the beat position.
    generate
        if (WORDS > 1) begin : g_multi_word
            assign fill_flat = {req_idx, beat};
        end else begin : g_single_word
            assign fill_flat = req_idx;
        end
    endgenerate

    assign hit       = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign rd_hit    = (state == IDLE) && cpu_rd && hit;
    assign last_beat = (beat == LAST_BEAT);

    assign cpu_rdata = rd_hit ? data_mem[req_flat] : '0;
    assign mem_wdata = cpu_wdata;
    assign mem_addr  = (state == FILL) ? (cpu_addr & ~LINE_MASK)
                                       : (cpu_addr & ~WORD_MASK);

    // NOTE: give every always_comb output a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        stall = 1'b0;
        unique case (state)
            IDLE:    stall = cpu_rd ? !hit : cpu_wr;  // a read wins over a write
            FILL:    stall = 1'b1;
            WRITE:   stall = !mem_wr_ack;
            default: stall = 1'b0;
        endcase
    end

    // Control FSM. Valid bits and the beat counter live here so reset clears
    // them at once. A fill cut short by reset leaves its line invalid.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat       <= '0;
            valid      <= '0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cpu_rd) begin
                        if (!hit) begin
                            state          <= FILL;
                            mem_rd_req     <= 1'b1;
                            valid[req_idx] <= 1'b0;
                            beat           <= '0;
                        end
                    end else if (cpu_wr) begin
                        state      <= WRITE;
                        mem_wr_req <= 1'b1;
                    end
                end
                FILL: begin
                    if (mem_rd_valid) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            valid[req_idx] <= 1'b1;
                            mem_rd_req     <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_wr_ack) begin
                        mem_wr_req <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays carry no reset. The valid bits alone decide
    // whether their contents mean anything, and a reset-free array maps onto RAM.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_rd_valid) begin
            data_mem[fill_flat] <= mem_rd_data;
            if (last_beat) begin
                tag_mem[req_idx] <= req_tag;
            end
        end
        if (state == WRITE && mem_wr_ack && hit) begin
            data_mem[req_flat] <= cpu_wdata;
        end
    end

`ifdef DM_CACHE_STATS_EN
    // fill_done marks the IDLE cycle right after a fill. The read completing
    // there was already counted as a miss, so it is not counted as a hit.
    logic fill_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_done <= (state == FILL) && mem_rd_valid && last_beat;
            if (rd_hit && !fill_done && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (state == IDLE && cpu_rd && !hit && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache.sv
// ----------------------------------------------------------------------------
// tb_dm_cache -- self-checking bench for dm_cache.
//
// Main instance: LINES=16, WORDS=4. The small line count makes random
// addresses collide often. A second instance with WORDS=1 covers the
// single-word-line case. The reference model is a word-addressed backing
// memory plus a table of which tag each index holds. Because the cache is
// write-through, the expected load data is always the backing-memory word.
// ----------------------------------------------------------------------------
module tb_dm_cache;

    localparam int NLINES = 16;
    localparam int NWORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n;

    // main instance signals
    logic        cpu_rd, cpu_wr, mem_rd_valid, mem_wr_ack;
    logic [31:0] cpu_addr, cpu_wdata, mem_rd_data;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        stall, hit, mem_rd_req, mem_wr_req;

    // single-word-line instance signals
    logic        s_rd, s_rd_valid;
    logic [31:0] s_addr, s_rd_data;
    logic [31:0] s_rdata, s_mem_addr, s_mem_wdata;
    logic        s_stall, s_hit, s_rd_req, s_wr_req;

`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt, s_hit_cnt, s_miss_cnt;
`endif

    dm_cache #(.ADDR_W(32), .DATA_W(32), .LINES(NLINES), .WORDS(NWORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall), .hit(hit),
        .mem_rd_req(mem_rd_req), .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack)
`ifdef DM_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    dm_cache #(.ADDR_W(32), .DATA_W(32), .LINES(NLINES), .WORDS(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd(s_rd), .cpu_wr(1'b0), .cpu_addr(s_addr), .cpu_wdata(32'h0),
        .cpu_rdata(s_rdata), .stall(s_stall), .hit(s_hit),
        .mem_rd_req(s_rd_req), .mem_addr(s_mem_addr),
        .mem_rd_valid(s_rd_valid), .mem_rd_data(s_rd_data),
        .mem_wr_req(s_wr_req), .mem_wdata(s_mem_wdata), .mem_wr_ack(1'b0)
`ifdef DM_CACHE_STATS_EN
        , .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] mem_model [int unsigned];
    bit          m_valid [NLINES];
    int unsigned m_tag   [NLINES];
    int          exp_hits;
    int          exp_misses;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned wa = a & ~32'h3;
        if (mem_model.exists(wa)) return mem_model[wa];
        return wa ^ (wa << 13) ^ 32'hC0DE_0000;
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / (4 * NWORDS)) % NLINES;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a / (4 * NWORDS * NLINES);
    endfunction

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 3) << 8) | ($urandom_range(0, NLINES-1) << 4) |
               ($urandom_range(0, NWORDS-1) << 2) | $urandom_range(0, 3);
    endfunction

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- CPU-side transactions ----------------
    task automatic idle_cycle(input bit noise);
        @(negedge clk);
        cpu_rd       = 1'b0;
        cpu_wr       = 1'b0;
        cpu_addr     = rand_addr();
        mem_rd_valid = noise ? 1'($urandom) : 1'b0;
        mem_rd_data  = $urandom;
        mem_wr_ack   = noise ? 1'($urandom) : 1'b0;
        #1;
        check("idle_stall", stall, 1'b0);
        check("idle_rd_req", mem_rd_req, 1'b0);
        check("idle_wr_req", mem_wr_req, 1'b0);
    endtask

    // Load; also_wr raises cpu_wr too, which must be treated as a plain read.
    task automatic cpu_read(input logic [31:0] a, input int max_gap, input bit also_wr);
        int unsigned idx = idx_of(a);
        int unsigned tg  = tag_of(a);
        logic [31:0] line = a & ~32'((4 * NWORDS) - 1);
        bit exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_wr_ack   = 1'b0;
        cpu_rd       = 1'b1;
        cpu_wr       = also_wr;
        cpu_wdata    = $urandom;
        cpu_addr     = a;
        #1;
        check("rd_hit", hit, exp_hit);
        check("rd_stall", stall, !exp_hit);
        if (exp_hit) begin
            check("rd_data", cpu_rdata, mem_rd(a));
            exp_hits++;
        end else begin
            exp_misses++;
            check("rd_req_idle", mem_rd_req, 1'b0);
            for (int b = 0; b < NWORDS; b++) begin
                int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
                for (int g = 0; g <= gap; g++) begin
                    @(negedge clk);
                    mem_rd_valid = 1'b0;
                    mem_wr_ack   = 1'($urandom);   // must be ignored in FILL
                    #1;
                    check("fill_req", mem_rd_req, 1'b1);
                    check("fill_stall", stall, 1'b1);
                    check("fill_addr", mem_addr, line);
                    if (g == gap) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_data  = mem_rd(line + 32'(4 * b));
                    end
                end
            end
            @(negedge clk);
            mem_rd_valid = 1'b0;
            mem_wr_ack   = 1'b0;
            #1;
            check("fill_done_stall", stall, 1'b0);
            check("fill_done_hit", hit, 1'b1);
            check("fill_done_req", mem_rd_req, 1'b0);
            check("fill_done_data", cpu_rdata, mem_rd(a));
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endtask

    // Store; ack arrives in the (ack_delay+1)-th cycle of mem_wr_req.
    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d, input int ack_delay);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        mem_wr_ack   = 1'b0;
        cpu_rd       = 1'b0;
        cpu_wr       = 1'b1;
        cpu_addr     = a;
        cpu_wdata    = d;
        #1;
        check("wr_stall_idle", stall, 1'b1);
        check("wr_req_idle", mem_wr_req, 1'b0);
        for (int c = 0; c <= ack_delay; c++) begin
            @(negedge clk);
            mem_rd_valid = 1'($urandom);           // must be ignored in WRITE
            mem_rd_data  = $urandom;
            #1;
            check("wr_req", mem_wr_req, 1'b1);
            check("wr_addr", mem_addr, a & ~32'h3);
            check("wr_data", mem_wdata, d);
            if (c == ack_delay) begin
                mem_wr_ack = 1'b1;
                #1;
                check("wr_ack_stall", stall, 1'b0);
            end else begin
                check("wr_stall", stall, 1'b1);
            end
        end
        mem_model[a & ~32'h3] = d;
    endtask

    task automatic check_stats(input string tag);
`ifdef DM_CACHE_STATS_EN
        check({tag, "_hit_cnt"}, hit_cnt, 32'(exp_hits));
        check({tag, "_miss_cnt"}, miss_cnt, 32'(exp_misses));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] far_addr;
        rst_n = 1'b0;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0; mem_wr_ack = 1'b0;
        s_rd = 1'b0; s_addr = '0; s_rd_valid = 1'b0; s_rd_data = '0;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_rd_req", mem_rd_req, 1'b0);
        check("rst_wr_req", mem_wr_req, 1'b0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_hit", hit, 1'b0);
        check_stats("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // single-word line: read 0x100, one beat 0xDEADBEEF
        @(negedge clk);
        s_rd = 1'b1; s_addr = 32'h0000_0100;
        #1;
        check("s_miss_stall", s_stall, 1'b1);
        check("s_miss_hit", s_hit, 1'b0);
        @(negedge clk);
        #1;
        check("s_fill_req", s_rd_req, 1'b1);
        check("s_fill_addr", s_mem_addr, 32'h0000_0100);
        s_rd_valid = 1'b1; s_rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        s_rd_valid = 1'b0;
        #1;
        check("s_done_stall", s_stall, 1'b0);
        check("s_done_data", s_rdata, 32'hDEAD_BEEF);
        check("s_done_hit", s_hit, 1'b1);
        @(negedge clk);
        s_rd = 1'b0;

        // four-word line: read 0x208 then 0x20C
        for (int w = 0; w < 4; w++) mem_model[32'h200 + 32'(4 * w)] = 32'h10 + 32'(w);
        cpu_read(32'h0000_0208, 0, 1'b0);
        check("line_word2", cpu_rdata, 32'h12);
        cpu_read(32'h0000_020C, 0, 1'b0);
        check("line_word3_stall", stall, 1'b0);
        check("line_word3", cpu_rdata, 32'h13);

        // write hit updates the cached word
        cpu_read(32'h0000_0100, 0, 1'b0);
        cpu_write(32'h0000_0100, 32'h5555_0000, 2);
        cpu_read(32'h0000_0100, 0, 1'b0);
        check("wr_hit_stall", stall, 1'b0);
        check("wr_hit_data", cpu_rdata, 32'h5555_0000);

        // write miss does not allocate
        cpu_write(32'h0000_0400, 32'hA0A0_0400, 1);
        cpu_read(32'h0000_0400, 0, 1'b0);
        check("no_alloc_data", cpu_rdata, 32'hA0A0_0400);
        check_stats("directed");

        // randomized mix
        for (int n = 0; n < 400; n++) begin
            int unsigned op = $urandom_range(0, 9);
            if (op < 5)      cpu_read(rand_addr(), 2, ($urandom_range(0, 7) == 0));
            else if (op < 8) cpu_write(rand_addr(), $urandom, $urandom_range(0, 3));
            else             idle_cycle(1'b1);
        end
        idle_cycle(1'b0);
        check_stats("random");

        // reset after beat 1 of a fill abandons the line
        far_addr = 32'h0800_0010;
        @(negedge clk);
        mem_rd_valid = 1'b0; mem_wr_ack = 1'b0;
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = far_addr;
        #1;
        check("rf_miss", stall, 1'b1);
        @(negedge clk);
        #1;
        check("rf_req", mem_rd_req, 1'b1);
        mem_rd_valid = 1'b1; mem_rd_data = mem_rd(far_addr);
        @(negedge clk);
        mem_rd_valid = 1'b0;
        #1;
        check("rf_req_beat1", mem_rd_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rf_req_reset", mem_rd_req, 1'b0);
        check("rf_wr_req_reset", mem_wr_req, 1'b0);
        check("rf_hit_reset", hit, 1'b0);
        model_reset();
        @(negedge clk);
        cpu_rd = 1'b0;
        rst_n  = 1'b1;

        // same line misses again, then three hits
        cpu_read(far_addr, 0, 1'b0);
        cpu_read(far_addr, 0, 1'b0);
        cpu_read(far_addr + 32'h4, 0, 1'b0);
        cpu_read(far_addr + 32'h8, 0, 1'b0);
        check("post_rst_misses", 32'(exp_misses), 32'd1);
        check_stats("post_rst");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0) cpu_read(rand_addr(), 1, 1'b0);
            else                            cpu_write(rand_addr(), $urandom, $urandom_range(0, 2));
        end
        idle_cycle(1'b0);
        check_stats("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0t expected < 200000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 Parameter ADDR_W, default 32, CPU/memory byte-address width.
REQ-002 Parameter DATA_W, default 32, word width; multiple of 8.
REQ-003 Parameter LINES, default 128, line count; power of 2, >=2.
REQ-004 Parameter WORDS, default 1, words per line; power of 2, >=1.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 cpu_rd  in  1  load request; held stable while stall=1.
REQ-008 cpu_wr  in  1  store request; held stable while stall=1.
REQ-009 cpu_addr  in  ADDR_W  byte address of request.
REQ-010 cpu_wdata  in  DATA_W  store data.
REQ-011 cpu_rdata  out  DATA_W  load data, valid when cpu_rd=1 and stall=0.
REQ-012 stall  out  1  CPU must hold its request.
REQ-013 hit  out  1  combinational tag hit for cpu_addr.
REQ-014 mem_rd_req  out  1  line-fill request, held until last beat.
REQ-015 mem_addr  out  ADDR_W  line-aligned in FILL; word-aligned cpu_addr in WRITE.
REQ-016 mem_rd_valid  in  1  one fill beat present on mem_rd_data.
REQ-017 mem_rd_data  in  DATA_W  fill beat data, ascending word order.
REQ-018 mem_wr_req  out  1  write-through request, held until mem_wr_ack.
REQ-019 mem_wdata  out  DATA_W  copy of cpu_wdata.
REQ-020 mem_wr_ack  in  1  single-cycle memory write completion.

Function
REQ-021 Address split, LSB first: byte offset log2(DATA_W/8), word select log2(WORDS), index log2(LINES), tag = remaining bits.
REQ-022 hit SHALL be 1 iff valid[index]=1 and tag[index] equals the cpu_addr tag field.
REQ-023 FSM states SHALL be IDLE, FILL, WRITE.
REQ-024 IDLE with cpu_rd and hit: cpu_rdata = addressed word combinationally, stall=0, no state change.
REQ-025 IDLE with cpu_rd and no hit: stall=1 same cycle; next edge enters FILL, clears valid[index], zeroes the beat counter.
REQ-026 FILL: mem_rd_req=1; each mem_rd_valid writes the word at the beat counter and increments it; on beat WORDS-1, write tag, set valid, return to IDLE.
REQ-027 Read-miss latency SHALL be WORDS beats plus one IDLE cycle, in which the now-hitting read completes with stall=0.
REQ-028 IDLE with cpu_wr: stall=1; next edge enters WRITE (write-through, no write-allocate).
REQ-029 WRITE: mem_wr_req=1; in the mem_wr_ack cycle stall=0, the cached word is updated if hit=1, and the next edge returns to IDLE.
REQ-030 cpu_rd and cpu_wr both 1 SHALL be handled as a read; the write is ignored.
REQ-031 mem_rd_valid outside FILL and mem_wr_ack outside WRITE SHALL be ignored.
REQ-032 In IDLE with no request, stall=0, mem_rd_req=0, and mem_wr_req=0.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, clear all valid bits and the beat counter, and drive mem_rd_req=0 and mem_wr_req=0.
REQ-034 Reset during FILL or WRITE SHALL abandon the transaction; partially filled lines SHALL remain invalid.
REQ-035 Tag and data arrays need not be reset; cpu_rdata SHALL reset to 0.

Configuration
REQ-036 With DM_CACHE_STATS_EN defined: 32-bit outputs hit_cnt and miss_cnt, reset to 0 and saturating at all-ones.
REQ-037 hit_cnt SHALL increment once per completed read hit; miss_cnt SHALL increment on each FILL entry.
REQ-038 Without DM_CACHE_STATS_EN, the counters and ports SHALL be absent and behaviour otherwise identical.

Verification
REQ-039 After reset with WORDS=1, read 0x0000_0100 -> stall=1, one FILL beat 0xDEAD_BEEF, next cycle stall=0, cpu_rdata=0xDEAD_BEEF, hit=1.
REQ-040 With WORDS=4, read 0x0000_0208 -> mem_addr=0x0000_0200, four beats 0x10,0x11,0x12,0x13 -> cpu_rdata=0x12; then read 0x0000_020C -> 0x13 with no stall.
REQ-041 Line at 0x100 cached; write 0x5555_0000 to 0x0000_0100 -> mem_wr_req held until ack on cycle 3; then read 0x100 -> 0x5555_0000 with no fill.
REQ-042 Write to uncached 0x0000_0400, then read 0x400 -> read misses and fills (no allocate).
REQ-043 Assert rst_n=0 after beat 1 of a 4-beat fill -> mem_rd_req=0 immediately; a later read of the same line misses.
REQ-044 With DM_CACHE_STATS_EN: 1 miss then 3 hits -> miss_cnt=1, hit_cnt=3.
